alu_op_sequencer: RTL and testbench

Registered command/issue stage wrapped around the combinational `alu_controller`. It accepts ALU commands over a valid/ready handshake and registers them onto the ALU operand/opcode inputs. One cycle later it captures the ALU result and flags into a small result FIFO, and presents them downstream over a second valid/ready handshake. It also keeps sticky overflow/carry status and a completed-result counter for software/scoreboard visibility.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_op_sequencer_if.sv | 33 +++
 rtl/alu_result_fifo.sv | 76 +++++++
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pkg: shared ALU opcodes, flag and result types                    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_WIDTH  = 8;
  localparam int ALU_OP_W   = 3;
  localparam int ALU_FLAG_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_EQ  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic carry;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_OP_W-1:0]  opcode;
    alu_flags_t           flags;
    logic [ALU_WIDTH-1:0] y;
  } alu_result_t;

  function automatic alu_flags_t make_flags(input logic overflow, input logic zero,
                                            input logic carry);
    alu_flags_t f;
    f.overflow = overflow;
    f.zero     = zero;
    f.carry    = carry;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_op_sequencer_if: command and result valid/ready channels          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_OP_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_a;
  logic [WIDTH-1:0]      in_b;
  logic [DEPTH-1:0]      in_opcode;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_y;
  logic [ALU_FLAG_W-1:0] out_flags;
  logic [DEPTH-1:0]      out_opcode;

  modport master (
    output in_valid, in_a, in_b, in_opcode, out_ready,
    input  in_ready, out_valid, out_y, out_flags, out_opcode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, out_ready,
    output in_ready, out_valid, out_y, out_flags, out_opcode
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_result_fifo: synchronous show-ahead FIFO of alu_result_t          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  alu_result_t push_data,
  input  logic        pop,
  output alu_result_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(FIFO_DEPTH);

  alu_result_t      mem_q [FIFO_DEPTH];
  alu_result_t      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == C_FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_op_sequencer: registered issue stage and result FIFO around ALU   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int DEPTH      = ALU_OP_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_op_sequencer_if.slave       bus,
  output logic [WIDTH-1:0]        alu_operand_a,
  output logic [WIDTH-1:0]        alu_operand_b,
  output logic [DEPTH-1:0]        alu_opcode,
  input  logic [WIDTH-1:0]        alu_y,
  input  logic                    alu_carry,
  input  logic                    alu_zero,
  input  logic                    alu_overflow,
  input  logic                    clear_sticky,
  output logic                    sticky_overflow,
  output logic                    sticky_carry,
  output logic [15:0]             result_count
);

  localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [DEPTH-1:0] alu_op_q, alu_op_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic             sticky_carry_q, sticky_carry_d;
  logic [15:0]      result_count_q, result_count_d;

  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic             accept;
  alu_result_t      push_data, head;

  // in_ready sees out_ready through fifo_pop: a full FIFO draining this
  // cycle still lets S1 advance and take a new command.
  assign fifo_pop     = !fifo_empty && bus.out_ready;
  assign fifo_push    = s1_valid_q && (!fifo_full || fifo_pop);
  assign bus.in_ready = !s1_valid_q || fifo_push;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    push_data.opcode = alu_op_q;
    push_data.flags  = make_flags(alu_overflow, alu_zero, alu_carry);
    push_data.y      = alu_y;
  end

  always_comb begin
    s1_valid_d     = s1_valid_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    sticky_ovf_d   = sticky_ovf_q;
    sticky_carry_d = sticky_carry_q;
    result_count_d = result_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      alu_a_d    = bus.in_a;
      alu_b_d    = bus.in_b;
      alu_op_d   = bus.in_opcode;
    end else if (fifo_push) begin
      s1_valid_d = 1'b0;
    end

    if (clear_sticky) begin
      sticky_ovf_d   = 1'b0;
      sticky_carry_d = 1'b0;
    end
    if (fifo_push && alu_overflow) begin
      sticky_ovf_d = 1'b1;
    end
    if (fifo_push && alu_carry) begin
      sticky_carry_d = 1'b1;
    end

    if (fifo_pop && (result_count_q != C_COUNT_MAX)) begin
      result_count_d = result_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      sticky_ovf_q   <= 1'b0;
      sticky_carry_q <= 1'b0;
      result_count_q <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      sticky_ovf_q   <= sticky_ovf_d;
      sticky_carry_q <= sticky_carry_d;
      result_count_q <= result_count_d;
    end
  end

  alu_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid  = !fifo_empty;
  assign bus.out_y      = head.y;
  assign bus.out_flags  = head.flags;
  assign bus.out_opcode = head.opcode;

  assign alu_operand_a   = alu_a_q;
  assign alu_operand_b   = alu_b_q;
  assign alu_opcode      = alu_op_q;
  assign sticky_overflow = sticky_ovf_q;
  assign sticky_carry    = sticky_carry_q;
  assign result_count    = result_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_op_sequencer: scoreboard bench with stand-in ALU model         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] flags;   // {overflow, zero, carry}
    logic [7:0] y;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  alu_operand_a, alu_operand_b, alu_y;
  logic [2:0]  alu_opcode;
  logic        alu_carry, alu_zero, alu_overflow;
  logic        clear_sticky, sticky_overflow, sticky_carry;
  logic [15:0] result_count;
  res_t        alu_stub;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops_total = 0;
  logic exp_sticky_ovf = 1'b0;
  logic exp_sticky_carry = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(8), .DEPTH(3)) bus ();

  alu_op_sequencer #(.WIDTH(8), .DEPTH(3), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .alu_operand_a   (alu_operand_a),
    .alu_operand_b   (alu_operand_b),
    .alu_opcode      (alu_opcode),
    .alu_y           (alu_y),
    .alu_carry       (alu_carry),
    .alu_zero        (alu_zero),
    .alu_overflow    (alu_overflow),
    .clear_sticky    (clear_sticky),
    .sticky_overflow (sticky_overflow),
    .sticky_carry    (sticky_carry),
    .result_count    (result_count)
  );

  // Arithmetic meaning of each opcode; carry is the borrow for SUB.
  function automatic res_t alu_ref(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op);
    res_t       r;
    logic [8:0] s;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r.y = s[7:0]; c = s[8];
                  v = (a[7] == b[7]) && (r.y[7] != a[7]); end
      3'd1: begin r.y = a - b; c = (a < b);
                  v = (a[7] != b[7]) && (r.y[7] != a[7]); end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = a ^ b;
      3'd5: r.y = a << b[2:0];
      3'd6: r.y = a >> b[2:0];
      default: r.y = (a == b) ? 8'd1 : 8'd0;
    endcase
    r.op    = op;
    r.flags = {v, (r.y == 8'd0), c};
    return r;
  endfunction

  assign alu_stub     = alu_ref(alu_operand_a, alu_operand_b, alu_opcode);
  assign alu_y        = alu_stub.y;
  assign alu_overflow = alu_stub.flags[2];
  assign alu_zero     = alu_stub.flags[1];
  assign alu_carry    = alu_stub.flags[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Input side of the scoreboard: every accepted command queues its result.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      exp_sticky_ovf   = 1'b0;
      exp_sticky_carry = 1'b0;
    end else if (bus.in_valid && bus.in_ready) begin
      res_t e;
      e = alu_ref(bus.in_a, bus.in_b, bus.in_opcode);
      exp_q.push_back(e);
      exp_sticky_ovf   = exp_sticky_ovf | e.flags[2];
      exp_sticky_carry = exp_sticky_carry | e.flags[0];
    end
  end

  // Output side: compares each consumed result against the queue head.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      pops_total = 0;
    end else begin
      check("result_count", 32'(result_count), 32'(pops_total));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got y=0x%0h op=%0d, expected no output",
                   bus.out_y, bus.out_opcode);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("out_y", 32'(bus.out_y), 32'(e.y));
          check("out_flags", 32'(bus.out_flags), 32'(e.flags));
          check("out_opcode", 32'(bus.out_opcode), 32'(e.op));
        end
        pops_total++;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_opcode = op;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #3;
      if (exp_q.size() == 0 && !bus.out_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
  endtask

  // Offers ncmd random commands over ncyc cycles with out_ready low.
  task automatic offer_stalled(input int ncmd, input int ncyc, output int accepted);
    logic [7:0] a, b;
    logic [2:0] op;
    accepted = 0;
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 3'($urandom_range(0, 7));
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = (accepted < ncmd);
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_opcode = op;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        accepted++;
        a  = 8'($urandom);
        b  = 8'($urandom);
        op = 3'($urandom_range(0, 7));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int   acc;
    logic acc_last;

    rst           = 1'b1;
    clear_sticky  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_opcode = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_y", 32'(bus.out_y), 0);
    check("rst_out_flags", 32'(bus.out_flags), 0);
    check("rst_out_opcode", 32'(bus.out_opcode), 0);
    check("rst_sticky_ovf", 32'(sticky_overflow), 0);
    check("rst_sticky_carry", 32'(sticky_carry), 0);
    check("rst_alu_a", 32'(alu_operand_a), 0);
    check("rst_alu_op", 32'(alu_opcode), 0);

    // ADD overflow case with the two-edge latency made explicit.
    bus.out_ready = 1'b1;
    send(8'h7F, 8'h01, 3'b000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
    check("lat_not_yet_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    #3;
    check("add_valid", 32'(bus.out_valid), 1);
    check("add_y", 32'(bus.out_y), 32'h80);
    check("add_flags", 32'(bus.out_flags), 32'b100);
    check("add_opcode", 32'(bus.out_opcode), 0);
    check("add_sticky_ovf", 32'(sticky_overflow), 1);

    // SUB borrow case.
    send(8'h00, 8'h01, 3'b001);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #3;
    check("sub_y", 32'(bus.out_y), 32'hFF);
    check("sub_flags", 32'(bus.out_flags), 32'b001);
    check("sub_sticky_carry", 32'(sticky_carry), 1);
    @(negedge clk);
    #3;
    check("count_after_two", 32'(result_count), 2);
    check("empty_after_two", 32'(bus.out_valid), 0);

    @(negedge clk);
    clear_sticky = 1'b1;
    @(negedge clk);
    clear_sticky = 1'b0;
    #3;
    check("clear_sticky_ovf", 32'(sticky_overflow), 0);
    check("clear_sticky_carry", 32'(sticky_carry), 0);

    // Backpressure: four results fill the FIFO, the fifth waits in S1.
    offer_stalled(6, 10, acc);
    check("stall_accepts", 32'(acc), 5);
    check("stall_in_ready", 32'(bus.in_ready), 0);
    check("stall_out_valid", 32'(bus.out_valid), 1);
    wait_drain(40);

    // Full FIFO with continuous traffic: one accept and one pop every cycle.
    offer_stalled(5, 8, acc);
    check("fill_accepts", 32'(acc), 5);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = 8'($urandom);
      bus.in_b      = 8'($urandom);
      bus.in_opcode = 3'($urandom_range(0, 7));
      #1;
      check("stream_in_ready", 32'(bus.in_ready), 1);
      check("stream_out_valid", 32'(bus.out_valid), 1);
    end
    wait_drain(40);

    // Set beats clear when both land on the same edge.
    @(negedge clk);
    clear_sticky = 1'b1;
    @(negedge clk);
    clear_sticky = 1'b0;
    send(8'h7F, 8'h01, 3'b000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear_sticky = 1'b1;
    @(negedge clk);
    #3;
    check("sticky_set_wins", 32'(sticky_overflow), 1);
    @(negedge clk);
    clear_sticky = 1'b0;
    #3;
    check("sticky_cleared_later", 32'(sticky_overflow), 0);
    wait_drain(20);

    // Reset with three results queued and a fourth in S1.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #3;
    check("pre_reset_out_valid", 32'(bus.out_valid), 1);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_count", 32'(result_count), 0);
    check("mid_rst_sticky", 32'({sticky_overflow, sticky_carry}), 0);
    bus.out_ready = 1'b1;
    send(8'h12, 8'h34, 3'b100);
    wait_drain(20);
    repeat (4) @(negedge clk);
    #3;
    check("post_rst_one_result", 32'(pops_total), 1);

    // Randomized traffic; commands are held until accepted.
    @(negedge clk);
    clear_sticky = 1'b1;
    @(negedge clk);
    clear_sticky     = 1'b0;
    exp_sticky_ovf   = 1'b0;
    exp_sticky_carry = 1'b0;
    acc_last = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || acc_last) begin
        bus.in_valid  = ($urandom_range(0, 2) != 0);
        bus.in_a      = 8'($urandom);
        bus.in_b      = 8'($urandom);
        bus.in_opcode = 3'($urandom_range(0, 7));
      end
      #1;
      acc_last = bus.in_valid && bus.in_ready;
    end
    wait_drain(60);
    check("rand_sticky_ovf", 32'(sticky_overflow), 32'(exp_sticky_ovf));
    check("rand_sticky_carry", 32'(sticky_carry), 32'(exp_sticky_carry));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
